// File: rtl/pdm_voice_scheduler.sv
// Sample-rate scheduler for the pdm modulator: on each sample tick it snapshots the voices,
// sums the gated ones one per clock, normalises by a power-of-two count and updates dc/gate together.
module pdm_voice_scheduler #(
    parameter int unsigned NUM_VOICES     = 8,
    parameter int unsigned PDM_RESOLUTION = 256,
    parameter int unsigned SAMPLE_DIV     = 2272
) (
    input  logic                                           clk_in,
    input  logic                                           rst_n_in,
    input  logic [NUM_VOICES*$clog2(PDM_RESOLUTION)-1:0]   voice_sample_in,
    input  logic [NUM_VOICES-1:0]                          voice_gate_in,
    output logic [$clog2(PDM_RESOLUTION)-1:0]              dc_out,
    output logic [NUM_VOICES-1:0]                          gate_out,
    output logic                                           sample_tick_out,
    output logic                                           busy_out
);

    localparam int unsigned W  = $clog2(PDM_RESOLUTION);
    localparam int unsigned IW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int unsigned SW = W + IW;
    localparam int unsigned AW = $clog2(NUM_VOICES) + 1;
    localparam int unsigned CW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [SW-1:0] MAX_MIX = SW'(PDM_RESOLUTION - 1);

    if (SAMPLE_DIV < NUM_VOICES + 3) begin : g_bad_div
        $error("SAMPLE_DIV must be at least NUM_VOICES+3");
    end

    typedef enum logic [1:0] {IDLE, ACCUM, NORM, UPDATE} state_t;

    state_t                      state;
    logic [CW-1:0]               tick_cnt;
    logic                        tick_c;
    logic [NUM_VOICES*W-1:0]     snap_sample;
    logic [NUM_VOICES-1:0]       snap_gate;
    logic [IW-1:0]               idx;
    logic [SW-1:0]               sum;
    logic [AW-1:0]               active;
    logic [W-1:0]                mix_q;
    logic [W-1:0]                cur_sample_c;
    logic [AW-1:0]               shift_c;
    logic [SW-1:0]               shifted_c;
    logic [W-1:0]                mix_c;

    // Free-running sample-rate divider; the wrap cycle is the sample tick.
    assign tick_c = (tick_cnt == CW'(SAMPLE_DIV - 1));

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            tick_cnt <= '0;
        end else if (tick_c) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + CW'(1);
        end
    end

    assign cur_sample_c = snap_sample[idx*W +: W];

    // shift = ceil(log2(active)); the mix is saturated even though the sum cannot exceed it.
    always_comb begin
        shift_c = '0;
        for (int s = 0; s < int'(IW); s++) begin
            if (32'(active) > (32'd1 << s)) begin
                shift_c = AW'(s + 1);
            end
        end
        shifted_c = sum >> shift_c;
        if (active == '0) begin
            mix_c = '0;
        end else if (shifted_c > MAX_MIX) begin
            mix_c = W'(PDM_RESOLUTION - 1);
        end else begin
            mix_c = W'(shifted_c);
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state           <= IDLE;
            snap_sample     <= '0;
            snap_gate       <= '0;
            idx             <= '0;
            sum             <= '0;
            active          <= '0;
            mix_q           <= '0;
            dc_out          <= '0;
            gate_out        <= '0;
            sample_tick_out <= 1'b0;
            busy_out        <= 1'b0;
        end else begin
            sample_tick_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (tick_c) begin
                        snap_sample <= voice_sample_in;
                        snap_gate   <= voice_gate_in;
                        sum         <= '0;
                        active      <= '0;
                        idx         <= '0;
                        busy_out    <= 1'b1;
                        state       <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (snap_gate[idx]) begin
                        sum    <= sum + SW'(cur_sample_c);
                        active <= active + AW'(1);
                    end
                    if (idx == IW'(NUM_VOICES - 1)) begin
                        state <= NORM;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                NORM: begin
                    mix_q <= mix_c;
                    state <= UPDATE;
                end
                UPDATE: begin
                    dc_out          <= mix_q;
                    gate_out        <= snap_gate;
                    sample_tick_out <= 1'b1;
                    busy_out        <= 1'b0;
                    state           <= IDLE;
                end
                default: begin
                    busy_out <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pdm_voice_scheduler.sv
// Directed bench for pdm_voice_scheduler: mixes, gate vectors, tick spacing, snapshot and reset behaviour.
module tb_pdm_voice_scheduler;

    localparam int unsigned NV = 8;
    localparam int unsigned RES = 256;
    localparam int unsigned SD = 64;
    localparam int unsigned W = 8;

    logic              clk_in = 1'b0;
    logic              rst_n_in = 1'b0;
    logic [NV*W-1:0]   voice_sample_in = '0;
    logic [NV-1:0]     voice_gate_in = '0;
    logic [W-1:0]      dc_out;
    logic [NV-1:0]     gate_out;
    logic              sample_tick_out;
    logic              busy_out;

    int checks = 0;
    int errors = 0;

    pdm_voice_scheduler #(
        .NUM_VOICES    (NV),
        .PDM_RESOLUTION(RES),
        .SAMPLE_DIV    (SD)
    ) dut (
        .clk_in         (clk_in),
        .rst_n_in       (rst_n_in),
        .voice_sample_in(voice_sample_in),
        .voice_gate_in  (voice_gate_in),
        .dc_out         (dc_out),
        .gate_out       (gate_out),
        .sample_tick_out(sample_tick_out),
        .busy_out       (busy_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic set_all(input logic [7:0] gate, input logic [7:0] val);
        voice_gate_in = gate;
        for (int i = 0; i < int'(NV); i++) voice_sample_in[i*W +: W] = val;
    endtask

    task automatic set_voice(input int i, input logic [7:0] val);
        voice_sample_in[i*W +: W] = val;
    endtask

    // Waits (bounded) for the update pulse, then checks spacing, payload and one-cycle pulse width.
    task automatic expect_sample(input string tag, input int exp_cycles,
                                 input logic [7:0] exp_dc, input logic [7:0] exp_gate);
        int cycles;
        cycles = 0;
        do begin
            @(negedge clk_in);
            cycles++;
        end while (!sample_tick_out && cycles < int'(3 * SD));
        check({tag, "_cycles"}, 32'(cycles), 32'(exp_cycles));
        check({tag, "_dc"}, 32'(dc_out), 32'(exp_dc));
        check({tag, "_gate"}, 32'(gate_out), 32'(exp_gate));
        @(negedge clk_in);
        check({tag, "_tick_low"}, 32'(sample_tick_out), 32'd0);
        check({tag, "_busy_low"}, 32'(busy_out), 32'd0);
        check({tag, "_dc_hold"}, 32'(dc_out), 32'(exp_dc));
    endtask

    initial begin
        // Reset state
        set_all(8'h04, 8'd255);
        set_voice(2, 8'd200);
        repeat (3) @(negedge clk_in);
        check("rst_dc", 32'(dc_out), 32'd0);
        check("rst_gate", 32'(gate_out), 32'd0);
        check("rst_tick", 32'(sample_tick_out), 32'd0);
        check("rst_busy", 32'(busy_out), 32'd0);
        rst_n_in = 1'b1;

        // 1: single gated voice, ungated voices ignored
        expect_sample("t1", int'(SD) + 10, 8'd200, 8'h04);

        // 2: three voices of 100 -> 300 >> 2
        set_all(8'h07, 8'd0);
        for (int i = 0; i < 3; i++) set_voice(i, 8'd100);
        expect_sample("t2", int'(SD) - 1, 8'd75, 8'h07);

        // 3: full scale on all voices
        set_all(8'hFF, 8'd255);
        expect_sample("t3", int'(SD) - 1, 8'd255, 8'hFF);

        // 4: all gates low
        set_all(8'h00, 8'd255);
        expect_sample("t4", int'(SD) - 1, 8'd0, 8'h00);

        // 5: input change two cycles after the tick edge must not leak into this sample
        set_all(8'h01, 8'd0);
        set_voice(0, 8'd50);
        repeat (SD - 9) @(negedge clk_in);
        check("t5_busy_mid", 32'(busy_out), 32'd1);
        check("t5_dc_mid", 32'(dc_out), 32'd0);
        set_voice(0, 8'd250);
        expect_sample("t5a", 8, 8'd50, 8'h01);
        expect_sample("t5b", int'(SD) - 1, 8'd250, 8'h01);

        // 6: reset in the middle of a sweep
        repeat (SD - 8) @(negedge clk_in);
        check("t6_busy_mid", 32'(busy_out), 32'd1);
        #1 rst_n_in = 1'b0;
        #1;
        check("t6_rst_dc", 32'(dc_out), 32'd0);
        check("t6_rst_gate", 32'(gate_out), 32'd0);
        check("t6_rst_busy", 32'(busy_out), 32'd0);
        check("t6_rst_tick", 32'(sample_tick_out), 32'd0);
        set_all(8'h18, 8'd0);
        set_voice(3, 8'd10);
        set_voice(4, 8'd20);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        expect_sample("t6", int'(SD) + 10, 8'd15, 8'h18);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
